// File: rtl/abc80_pkg.sv
// Shared types and defaults for the ABC80 video RAM arbitration logic.
// Holds the mode encoding and the read-data destination tag.
// No logic; imported by the arbiter.
package abc80_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 8;

  // Arbiter operating mode: normal CPU/video sharing, or download in progress
  typedef enum logic {
    NORMAL = 1'b0,
    LOAD   = 1'b1
  } mode_t;

  // Destination of the RAM read data one cycle after a grant
  typedef enum logic [1:0] {
    NONE = 2'd0,
    VID  = 2'd1,
    CPU  = 2'd2
  } rtag_t;

endpackage

// File: rtl/abc80_dl_buffer.sv
// One-entry holding register for a download write that lost arbitration.
// Latency: captured at the end of the cycle the write is pushed; cleared when popped.
// Backpressure: none; a new push overwrites a held entry, the producer paces itself.
module abc80_dl_buffer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              vld,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Hold the latest ungranted write until the arbiter retires it
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vld  <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (push) begin
      vld  <= 1'b1;
      addr <= push_addr;
      data <= push_data;
    end else if (pop) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/abc80_vram_arbiter.sv
// Shares one synchronous text RAM between video scanout, Z80 CPU and HPS download.
// Latency: video read 2 cycles; CPU read ack 2 / write ack 1 cycle after grant; download ack 1.
// Backpressure: video never stalls; CPU held through cpu_wait; download retried from a 1-entry buffer.
module abc80_vram_arbiter
  import abc80_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  input  logic              dl_en,
  input  logic              dl_req,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [DATA_W-1:0] dl_wdata,
  output logic              dl_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  mode_t             mode_q, mode_d;
  logic              dl_en_q;
  logic              cpu_busy_q;
  rtag_t             rtag_q;
  logic              cpu_wr_ack_q;
  logic              cpu_rd_ack_q;
  logic [ADDR_W-1:0] ram_addr_q;

  logic              pend_vld;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;

  logic              vid_gnt, cpu_gnt, dl_gnt;
  logic              dl_cand;
  logic [ADDR_W-1:0] dl_cur_addr;
  logic [DATA_W-1:0] dl_cur_data;

  // A fresh strobe takes precedence over the held entry (it overwrites it anyway)
  assign dl_cand     = dl_req | pend_vld;
  assign dl_cur_addr = dl_req ? dl_addr  : pend_addr;
  assign dl_cur_data = dl_req ? dl_wdata : pend_data;

  abc80_dl_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_dl_buffer (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (dl_req & ~dl_gnt),
    .push_addr (dl_addr),
    .push_data (dl_wdata),
    .pop       (dl_gnt),
    .vld       (pend_vld),
    .addr      (pend_addr),
    .data      (pend_data)
  );

  // Fixed priority: video, then CPU (normal mode, nothing outstanding), then download (load mode)
  always_comb begin
    vid_gnt = 1'b0;
    cpu_gnt = 1'b0;
    dl_gnt  = 1'b0;
    if (!reset) begin
      if (vid_req)
        vid_gnt = 1'b1;
      else if (mode_q == NORMAL && cpu_req && !cpu_busy_q)
        cpu_gnt = 1'b1;
      else if (mode_q == LOAD && dl_cand)
        dl_gnt = 1'b1;
    end
  end

  // Drive the RAM port from the winner; the address is held when nobody wins
  always_comb begin
    ram_addr  = ram_addr_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (vid_gnt) begin
      ram_addr = vid_addr;
    end else if (cpu_gnt) begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we;
      if (cpu_we)
        ram_wdata = cpu_wdata;
    end else if (dl_gnt) begin
      ram_addr  = dl_cur_addr;
      ram_we    = 1'b1;
      ram_wdata = dl_cur_data;
    end
  end

  // Mode register and download-enable edge detector
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mode_q  <= NORMAL;
      dl_en_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      dl_en_q <= dl_en;
    end
  end

  // Enter load on a rising dl_en; leave only once no download write is left over
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      NORMAL: if (dl_en && !dl_en_q) mode_d = LOAD;
      LOAD:   if (!dl_en && !dl_cand) mode_d = NORMAL;
    endcase
  end

  // Grant bookkeeping, read-tag pipeline and registered responses
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cpu_busy_q   <= 1'b0;
      ram_addr_q   <= '0;
      rtag_q       <= NONE;
      cpu_wr_ack_q <= 1'b0;
      cpu_rd_ack_q <= 1'b0;
      dl_ack       <= 1'b0;
      vid_valid    <= 1'b0;
      vid_data     <= '0;
      cpu_rdata    <= '0;
    end else begin
      // CPU request is ignored from grant until the ack cycle has passed
      if (cpu_gnt)
        cpu_busy_q <= 1'b1;
      else if (cpu_ack)
        cpu_busy_q <= 1'b0;

      if (vid_gnt || cpu_gnt || dl_gnt)
        ram_addr_q <= ram_addr;

      rtag_q       <= vid_gnt ? VID : ((cpu_gnt && !cpu_we) ? CPU : NONE);
      cpu_wr_ack_q <= cpu_gnt & cpu_we;
      dl_ack       <= dl_gnt;

      vid_valid    <= (rtag_q == VID);
      cpu_rd_ack_q <= (rtag_q == CPU);
      if (rtag_q == VID)
        vid_data <= ram_rdata;
      if (rtag_q == CPU)
        cpu_rdata <= ram_rdata;
    end
  end

  assign cpu_ack  = cpu_wr_ack_q | cpu_rd_ack_q;
  assign cpu_wait = cpu_req & ~cpu_ack;

endmodule
